ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host receiver, the successor to the single-byte PS/2 receiver.
- Adds a configurable glitch filter on ps2c and odd-parity checking.
- Adds start/stop framing checks and a mid-frame timeout watchdog.
- Received bytes go into an output FIFO with a valid/ready handshake, so the APB peripheral wrapper can read bytes in bursts without losing keystrokes.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_clk_filter.sv | 39 +++
 rtl/ps2_rx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receiver with output FIFO.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_SHIFT_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } ps2_rx_state_e;

  // Parity bit that makes data plus parity contain an odd number of ones.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Glitch filter on ps2c: the level changes only after FILTER_LEN equal samples.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c,
  output logic filt_o,
  output logic fall_tick_c
);

  logic [FILTER_LEN-1:0] sr_q, sr_d;
  logic                  filt_q, filt_d;

  always_comb begin
    sr_d   = {sr_q[FILTER_LEN-2:0], ps2c};
    filt_d = filt_q;
    if (&sr_q) begin
      filt_d = 1'b1;
    end else if (~|sr_q) begin
      filt_d = 1'b0;
    end
  end

  // Idle-high reset so no edge is seen when reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '1;
      filt_q <= 1'b1;
    end else begin
      sr_q   <= sr_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o      = filt_q;
  assign fall_tick_c = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with framing/parity/timeout checks and an output FIFO.
// Optional error counters are compiled in with `define PS2_RX_ERR_CNT_EN.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ps2c,
  input  logic                               ps2d,
  input  logic                               rx_en,
  output logic [7:0]                         rx_data,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               busy,
  output logic                               overflow,
  input  logic                               clr_status,
  output logic                               err_parity,
  output logic                               err_frame,
  output logic                               err_timeout,
  output logic [7:0]                         cnt_parity,
  output logic [7:0]                         cnt_frame,
  output logic [7:0]                         cnt_timeout
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES);

  logic ps2c_filt, fall_tick;
  logic unused_filt;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2c        (ps2c),
    .filt_o      (ps2c_filt),
    .fall_tick_c (fall_tick)
  );

  // Only edges of the filtered clock matter to the receiver.
  assign unused_filt = ps2c_filt;

  ps2_rx_state_e             state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [WW-1:0]             wdog_q, wdog_d;
  logic [PS2_SHIFT_BITS-1:0] shift_q, shift_d;
  logic                      err_par_d, err_frm_d, err_to_d, push_req;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wdog_d    = wdog_q;
    shift_d   = shift_q;
    err_par_d = 1'b0;
    err_frm_d = 1'b0;
    err_to_d  = 1'b0;
    push_req  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall_tick && rx_en && !ps2d) begin
          state_d = RECV;
          cnt_d   = '0;
          wdog_d  = '0;
        end
      end
      RECV: begin
        if (fall_tick) begin
          shift_d = {ps2d, shift_q[PS2_SHIFT_BITS-1:1]};
          cnt_d   = cnt_q + 4'd1;
          wdog_d  = '0;
          if (cnt_q == 4'(PS2_SHIFT_BITS - 1)) begin
            state_d = CHECK;
          end
        end else if (wdog_q == WW'(TIMEOUT_CYCLES - 2)) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!shift_q[9]) begin
          err_frm_d = 1'b1;
        end else if (shift_q[8] != odd_parity(shift_q[7:0])) begin
          err_par_d = 1'b1;
        end else begin
          push_req = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          pop, push_ok, ovf_d;

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    pop     = rx_valid & rx_ready;
    push_ok = push_req & ((level_q != LW'(FIFO_DEPTH)) | pop);
    level_d = level_q + LW'(push_ok) - LW'(pop);
    ovf_d   = (push_req & ~push_ok) | (overflow & ~clr_status);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wdog_q      <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      rx_valid    <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdog_q      <= wdog_d;
      shift_q     <= shift_d;
      level_q     <= level_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q[7:0];
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      rx_valid    <= (level_d != '0);
      busy        <= (state_d != IDLE);
      overflow    <= ovf_d;
      err_parity  <= err_par_d;
      err_frame   <= err_frm_d;
      err_timeout <= err_to_d;
    end
  end

  assign rx_data    = mem_q[rd_ptr_q];
  assign fifo_level = level_q;

`ifdef PS2_RX_ERR_CNT_EN
  logic [7:0] cnt_par_q, cnt_frm_q, cnt_to_q;

  // Saturating counters; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_par_q <= '0;
      cnt_frm_q <= '0;
      cnt_to_q  <= '0;
    end else begin
      if (err_par_d) cnt_par_q <= (cnt_par_q == 8'hFF) ? cnt_par_q : cnt_par_q + 8'd1;
      else if (clr_status) cnt_par_q <= '0;
      if (err_frm_d) cnt_frm_q <= (cnt_frm_q == 8'hFF) ? cnt_frm_q : cnt_frm_q + 8'd1;
      else if (clr_status) cnt_frm_q <= '0;
      if (err_to_d) cnt_to_q <= (cnt_to_q == 8'hFF) ? cnt_to_q : cnt_to_q + 8'd1;
      else if (clr_status) cnt_to_q <= '0;
    end
  end

  assign cnt_parity  = cnt_par_q;
  assign cnt_frame   = cnt_frm_q;
  assign cnt_timeout = cnt_to_q;
`else
  assign cnt_parity  = 8'd0;
  assign cnt_frame   = 8'd0;
  assign cnt_timeout = 8'd0;
`endif

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: framing, parity, timeout, FIFO overflow, filter and reset.
module tb_ps2_rx_fifo;

  localparam int unsigned FL = 4;
  localparam int unsigned FD = 4;
  localparam int unsigned TO = 200;
  localparam int unsigned H  = 8;

  logic       clk = 1'b0;
  logic       rst_n, ps2c, ps2d, rx_en, rx_ready, clr_status;
  logic [7:0] rx_data, cnt_parity, cnt_frame, cnt_timeout;
  logic       rx_valid, busy, overflow, err_parity, err_frame, err_timeout;
  logic [2:0] fifo_level;

  int checks   = 0;
  int failures = 0;
  int n_par = 0, n_frm = 0, n_to = 0;
  logic [7:0] vals [5];

  ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fifo_level(fifo_level), .busy(busy), .overflow(overflow),
    .clr_status(clr_status), .err_parity(err_parity), .err_frame(err_frame),
    .err_timeout(err_timeout), .cnt_parity(cnt_parity), .cnt_frame(cnt_frame),
    .cnt_timeout(cnt_timeout)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_parity)  n_par++;
      if (err_frame)   n_frm++;
      if (err_timeout) n_to++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic send_bit(input logic b);
    ps2d = b;
    repeat (H) tick();
    ps2c = 1'b0;
    repeat (H) tick();
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pbit);
    send_bit(stop);
    ps2d = 1'b1;
    repeat (H) tick();
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    rst_n = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; rx_ready = 1'b0; clr_status = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_errs", 32'({err_parity, err_frame, err_timeout}), 32'd0);
    rst_n = 1'b1;
    repeat (H) tick();

    // Clean 0x1C with exact latency on the stop bit.
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'((8'h1C >> i) & 8'h01));
    send_bit(1'b0);
    ps2d = 1'b1;
    repeat (H) tick();
    ps2c = 1'b0;
    repeat (FL + 1) tick();
    chk("lat_valid_early", 32'(rx_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(rx_valid), 32'd1);
    chk("lat_data", 32'(rx_data), 32'h1C);
    chk("lat_level", 32'(fifo_level), 32'd1);
    repeat (H - FL - 2) tick();
    ps2c = 1'b1;
    repeat (H) tick();
    chk("clean_no_err", 32'(n_par + n_frm + n_to), 32'd0);
    pop_one();
    chk("pop_level", 32'(fifo_level), 32'd0);
    chk("pop_valid", 32'(rx_valid), 32'd0);

    // Bad parity then a good 0x32.
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("par_pulse", 32'(n_par), 32'd1);
    chk("par_level", 32'(fifo_level), 32'd0);
`ifdef PS2_RX_ERR_CNT_EN
    chk("par_cnt", 32'(cnt_parity), 32'd1);
`else
    chk("par_cnt", 32'(cnt_parity), 32'd0);
`endif
    send_frame(8'h32, par(8'h32), 1'b1);
    chk("after_par_level", 32'(fifo_level), 32'd1);
    chk("after_par_data", 32'(rx_data), 32'h32);
    chk("after_par_npar", 32'(n_par), 32'd1);
    pop_one();

    // Stop bit low.
    send_frame(8'h55, par(8'h55), 1'b0);
    chk("frm_pulse", 32'(n_frm), 32'd1);
    chk("frm_level", 32'(fifo_level), 32'd0);
    chk("frm_busy", 32'(busy), 32'd0);

    // Watchdog: start plus 4 data bits, then ps2c stalls high.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2d = 1'b1;
    repeat (H) tick();
    ps2c = 1'b0;
    repeat (H) tick();
    ps2c = 1'b1;
    repeat (FL + TO - 1 - H) tick();
    chk("to_early", 32'(err_timeout), 32'd0);
    chk("to_busy_early", 32'(busy), 32'd1);
    tick();
    chk("to_pulse", 32'(err_timeout), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    tick();
    chk("to_count", 32'(n_to), 32'd1);
    chk("to_level", 32'(fifo_level), 32'd0);
    repeat (H) tick();
    send_frame(8'hF0, par(8'hF0), 1'b1);
    chk("f0_level", 32'(fifo_level), 32'd1);
    chk("f0_data", 32'(rx_data), 32'hF0);
    pop_one();

    // Five frames into a four-entry FIFO.
    for (int i = 0; i < 5; i++) send_frame(vals[i], par(vals[i]), 1'b1);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(rx_data), 32'(vals[i]));
      pop_one();
    end
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_valid", 32'(rx_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Short glitches with data low must not start a frame.
    ps2d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ps2c = 1'b0;
      repeat (FL - 1) tick();
      ps2c = 1'b1;
      repeat (FL + 1) tick();
      chk("glitch_busy", 32'(busy), 32'd0);
    end
    ps2d = 1'b1;
    repeat (H) tick();

    // rx_en low: frame ignored.
    rx_en = 1'b0;
    send_frame(8'h3C, par(8'h3C), 1'b1);
    chk("en_level", 32'(fifo_level), 32'd0);
    chk("en_busy", 32'(busy), 32'd0);
    rx_en = 1'b1;

    // Reset mid-frame flushes FIFO and returns to idle.
    send_frame(8'hA5, par(8'hA5), 1'b1);
    chk("pre_rst_level", 32'(fifo_level), 32'd1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_level", 32'(fifo_level), 32'd0);
    chk("mrst_valid", 32'(rx_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    ps2d = 1'b1;
    repeat (H) tick();
    send_frame(8'h1C, par(8'h1C), 1'b1);
    chk("post_rst_data", 32'(rx_data), 32'h1C);
    chk("post_rst_level", 32'(fifo_level), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
